// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM with cache handshakes, retire counter and timeout detection
module multicycle_control #(
    parameter int ALUOP_W     = 3,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               i_req,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               d_read,
    output logic               d_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               alu_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               sign_xtend,
    output logic               mem2reg,
    output logic               illegal,
    output logic               error,
    output logic [CNT_W-1:0]   retired
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, ERROR} state_t;
    typedef enum logic [2:0] {K_ALU, K_J, K_JR, K_BEQ, K_BNE, K_LOAD, K_STORE, K_ILL} kind_t;
    localparam int WW = $clog2(MEM_TIMEOUT + 2);

    state_t state, next;
    kind_t kind, d_kind;
    logic [WW-1:0] wait_cnt;
    logic [ALUOP_W-1:0] d_alu;
    logic d_reg_dst, d_alu_src, d_sign, d_mem2reg, retire, timeout;

    // instruction class and control fields from the opcode/funct currently on the IR
    always_comb begin
        d_kind = K_ILL;
        d_alu = '1;
        d_reg_dst = 1'b0;
        d_alu_src = 1'b0;
        d_sign = 1'b0;
        d_mem2reg = 1'b0;
        casez (opcode)
            6'b000000: begin
                d_kind = funct[5:1] == 5'b00100 ? K_JR : K_ALU;
                d_reg_dst = 1'b1;
                d_sign = ~funct[0];
                casez (funct)
                    6'b10000?: d_alu = ALUOP_W'(3'd0);
                    6'b10001?: d_alu = ALUOP_W'(3'd1);
                    6'b000000: d_alu = ALUOP_W'(3'd2);
                    6'b000010: d_alu = ALUOP_W'(3'd3);
                    6'b100100: d_alu = ALUOP_W'(3'd4);
                    6'b100101: d_alu = ALUOP_W'(3'd5);
                    6'b100110: d_alu = ALUOP_W'(3'd6);
                    default: ;
                endcase
            end
            6'b00001?: d_kind = K_J;
            6'b0010??: begin
                d_kind = K_ALU;
                d_alu_src = 1'b1;
                d_sign = ~opcode[0];
                d_alu = opcode[1] ? ALUOP_W'(3'd2) : ALUOP_W'(3'd0);
            end
            6'b0011??: begin
                d_kind = K_ALU;
                d_alu_src = 1'b1;
                d_alu = opcode[1:0] == 2'b11 ? '1 : ALUOP_W'({1'b1, opcode[1:0]});
            end
            6'b00010?: begin
                d_kind = opcode[0] ? K_BNE : K_BEQ;
                d_alu = ALUOP_W'(3'd1);
            end
            6'b100???, 6'b1010??: begin
                d_kind = opcode[3] ? K_STORE : K_LOAD;
                d_alu = ALUOP_W'(3'd0);
                d_alu_src = 1'b1;
                d_sign = 1'b1;
                d_mem2reg = ~opcode[3];
            end
            default: ;
        endcase
    end

    // next state and strobes; everything is held low while rst is asserted
    always_comb begin
        next = state;
        i_req = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_src = 2'd0;
        d_read = 1'b0;
        d_write = 1'b0;
        reg_write = 1'b0;
        illegal = 1'b0;
        timeout = MEM_TIMEOUT != 0 && wait_cnt == WW'(MEM_TIMEOUT - 1);
        if (!rst) begin
            case (state)
                FETCH: begin
                    i_req = 1'b1;
                    ir_write = imem_ready;
                    pc_write = imem_ready;
                    next = imem_ready ? DECODE : timeout ? ERROR : FETCH;
                end
                DECODE: begin
                    illegal = d_kind == K_ILL;
                    pc_write = d_kind == K_J || d_kind == K_JR;
                    pc_src = d_kind == K_JR ? 2'd3 : d_kind == K_J ? 2'd2 : 2'd0;
                    next = pc_write || illegal ? FETCH : EXEC;
                end
                EXEC: begin
                    pc_write = kind == K_BEQ ? zero : kind == K_BNE ? ~zero : 1'b0;
                    pc_src = kind == K_BEQ || kind == K_BNE ? 2'd1 : 2'd0;
                    next = kind == K_BEQ || kind == K_BNE ? FETCH :
                           kind == K_LOAD || kind == K_STORE ? MEM : WB;
                end
                MEM: begin
                    d_read = kind == K_LOAD;
                    d_write = kind == K_STORE;
                    next = dmem_ready ? (kind == K_LOAD ? WB : FETCH) : timeout ? ERROR : MEM;
                end
                WB: begin
                    reg_write = 1'b1;
                    next = FETCH;
                end
                default: ;
            endcase
        end
        retire = next == FETCH && state != FETCH;
    end

    // state, wait counter, retire count, sticky error and per-instruction decoded fields
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            kind <= K_ALU;
            wait_cnt <= '0;
            retired <= '0;
            error <= 1'b0;
            alu_op <= '1;
            reg_dst <= 1'b0;
            alu_src <= 1'b0;
            sign_xtend <= 1'b0;
            mem2reg <= 1'b0;
        end else begin
            state <= next;
            wait_cnt <= next == state && (state == FETCH || state == MEM) ? wait_cnt + WW'(1) : '0;
            retired <= retired + CNT_W'(retire);
            error <= next == ERROR;
            if (state == DECODE) begin
                kind <= d_kind;
                alu_op <= d_alu;
                reg_dst <= d_reg_dst;
                alu_src <= d_alu_src;
                sign_xtend <= d_sign;
                mem2reg <= d_mem2reg;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed instruction sequences checked every cycle against a trace-level model
module tb_multicycle_control;
    logic clk = 1'b0, rst = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic i_req, ir_write, pc_write, d_read, d_write, reg_write, reg_dst, alu_src;
    logic sign_xtend, mem2reg, illegal, error;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic [31:0] retired;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .i_req(i_req),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .d_read(d_read),
        .d_write(d_write), .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
        .alu_op(alu_op), .sign_xtend(sign_xtend), .mem2reg(mem2reg), .illegal(illegal),
        .error(error), .retired(retired)
    );

    always #5 clk = ~clk;

    localparam int ALU = 0, J = 1, JR = 2, BEQ = 3, BNE = 4, LD = 5, ST = 6, ILL = 7;
    // strobe vector: i_req ir_write pc_write pc_src[1:0] d_read d_write reg_write illegal error
    localparam logic [9:0] S_NONE = 10'b0, S_WAIT = 10'b1000000000, S_ACC = 10'b1110000000;
    localparam logic [9:0] S_WB = 10'b0000000100, S_ERR = 10'b0000000001;
    localparam logic [6:0] RST_FLD = 7'b0000111;

    int passed = 0, checks = 0, ncyc = 0, n;
    logic chk_en = 1'b0;
    logic [9:0] exp_s;
    logic [6:0] exp_f, m_fld;
    logic [31:0] exp_r, m_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    endtask

    // spec decode table expressed arithmetically: class plus {reg_dst, alu_src, sign, mem2reg, alu}
    function automatic void model_dec(input int op, input int fn, output int cls, output logic [6:0] fld);
        logic rd = 1'b0, src = 1'b0, sx = 1'b0, m2r = 1'b0;
        int alu = 7;
        cls = ILL;
        if (op == 0) begin
            rd = 1'b1;
            sx = (fn % 2) == 0;
            cls = (fn == 8 || fn == 9) ? JR : ALU;
            if (fn == 32 || fn == 33) alu = 0;
            else if (fn == 34 || fn == 35) alu = 1;
            else if (fn == 0) alu = 2;
            else if (fn == 2) alu = 3;
            else if (fn >= 36 && fn <= 38) alu = fn - 32;
        end else if (op == 2 || op == 3) cls = J;
        else if (op >= 8 && op <= 15) begin
            cls = ALU;
            src = 1'b1;
            if (op <= 11) begin
                alu = op <= 9 ? 0 : 2;
                sx = (op % 2) == 0;
            end else alu = op == 15 ? 7 : op - 8;
        end else if (op == 4 || op == 5) begin
            cls = op == 4 ? BEQ : BNE;
            alu = 1;
        end else if (op >= 32 && op <= 43) begin
            cls = op <= 39 ? LD : ST;
            alu = 0;
            src = 1'b1;
            sx = 1'b1;
            m2r = op <= 39;
        end
        fld = {rd, src, sx, m2r, 3'(alu)};
    endfunction

    // one clock cycle: drive inputs, publish expectation, advance to just after the next edge
    task automatic cycle(input logic r, input logic im, input logic dm, input logic [9:0] s);
        rst = r;
        imem_ready = im;
        dmem_ready = dm;
        exp_s = s;
        exp_f = m_fld;
        exp_r = m_ret;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    // whole instruction: wi fetch stalls, wd memory stalls, branch flag z; returns cycle count
    task automatic run(input int op, input int fn, input int wi, input int wd, input logic z, output int cyc);
        int cls;
        logic [6:0] fld;
        logic jmp;
        model_dec(op, fn, cls, fld);
        opcode = 6'(op);
        funct = 6'(fn);
        zero = z;
        ncyc = 0;
        jmp = cls == J || cls == JR;
        repeat (wi) cycle(1'b0, 1'b0, 1'b1, S_WAIT);
        cycle(1'b0, 1'b1, 1'b1, S_ACC);
        cycle(1'b0, 1'b1, 1'b1, {2'b00, jmp, cls == JR ? 2'd3 : jmp ? 2'd2 : 2'd0, 3'b000, cls == ILL, 1'b0});
        m_fld = fld;
        if (cls == BEQ || cls == BNE)
            cycle(1'b0, 1'b1, 1'b1, {2'b00, cls == BEQ ? z : !z, 2'b01, 5'b0});
        else if (cls == LD || cls == ST) begin
            cycle(1'b0, 1'b1, 1'b1, S_NONE);
            repeat (wd) cycle(1'b0, 1'b1, 1'b0, {5'b0, cls == LD, cls == ST, 3'b0});
            cycle(1'b0, 1'b1, 1'b1, {5'b0, cls == LD, cls == ST, 3'b0});
            if (cls == LD) cycle(1'b0, 1'b1, 1'b1, S_WB);
        end else if (cls == ALU) begin
            cycle(1'b0, 1'b1, 1'b1, S_NONE);
            cycle(1'b0, 1'b1, 1'b1, S_WB);
        end
        cyc = ncyc;
        m_ret++;
    endtask

    // single compare process, mid-cycle, against the model's expectation
    always @(negedge clk) begin
        if (chk_en) begin
            chk("strobes", 32'({i_req, ir_write, pc_write, pc_src, d_read, d_write, reg_write, illegal, error}), 32'(exp_s));
            chk("fields", 32'({reg_dst, alu_src, sign_xtend, mem2reg, alu_op}), 32'(exp_f));
            chk("retired", retired, exp_r);
        end
    end

    initial begin
        int cls;
        logic [6:0] fld;
        m_fld = RST_FLD;
        m_ret = 0;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 1'b1, S_NONE);
        run(0, 32, 0, 0, 1'b0, n);
        chk("add_latency", 32'(n), 32'd4);
        chk("add_retired", retired, 32'd1);
        chk("add_alu_op", 32'(alu_op), 32'd0);
        chk("add_reg_dst", 32'(reg_dst), 32'd1);
        run(35, 0, 0, 3, 1'b0, n);
        chk("lw_latency", 32'(n), 32'd8);
        chk("lw_mem2reg", 32'(mem2reg), 32'd1);
        run(4, 0, 0, 0, 1'b1, n);
        chk("beq_latency", 32'(n), 32'd3);
        run(5, 0, 0, 0, 1'b1, n);
        chk("bne_latency", 32'(n), 32'd3);
        run(2, 0, 0, 0, 1'b0, n);
        chk("j_latency", 32'(n), 32'd2);
        run(43, 0, 0, 0, 1'b0, n);
        chk("sw_latency", 32'(n), 32'd4);
        run(0, 34, 15, 0, 1'b0, n);
        chk("sub_stall15_latency", 32'(n), 32'd19);
        run(0, 0, 0, 0, 1'b0, n);
        run(0, 2, 0, 0, 1'b0, n);
        run(0, 37, 0, 0, 1'b0, n);
        run(0, 42, 0, 0, 1'b0, n);
        run(8, 0, 0, 0, 1'b0, n);
        run(11, 0, 0, 0, 1'b0, n);
        run(12, 0, 0, 0, 1'b0, n);
        run(14, 0, 0, 0, 1'b0, n);
        run(15, 0, 0, 0, 1'b0, n);
        chk("lui_alu_op", 32'(alu_op), 32'd7);
        run(0, 8, 0, 0, 1'b0, n);
        chk("jr_latency", 32'(n), 32'd2);
        run(4, 0, 0, 0, 1'b0, n);
        run(5, 0, 0, 0, 1'b0, n);
        run(63, 0, 2, 0, 1'b0, n);
        chk("illegal_latency", 32'(n), 32'd4);
        run(32, 0, 0, 15, 1'b0, n);
        chk("lb_stall15_latency", 32'(n), 32'd20);
        run(41, 0, 1, 2, 1'b0, n);
        chk("retired_total", retired, 32'd22);
        // reset in the middle of a load's memory wait
        model_dec(35, 0, cls, fld);
        opcode = 6'd35;
        cycle(1'b0, 1'b1, 1'b1, S_ACC);
        cycle(1'b0, 1'b1, 1'b1, S_NONE);
        m_fld = fld;
        cycle(1'b0, 1'b1, 1'b1, S_NONE);
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 10'b0000010000);
        cycle(1'b1, 1'b1, 1'b0, S_NONE);
        m_fld = RST_FLD;
        m_ret = 0;
        // fetch timeout into the sticky error state, then recover with rst
        repeat (16) cycle(1'b0, 1'b0, 1'b1, S_WAIT);
        repeat (3) cycle(1'b0, 1'b1, 1'b1, S_ERR);
        cycle(1'b1, 1'b1, 1'b1, S_ERR);
        run(0, 32, 0, 0, 1'b0, n);
        chk("post_reset_retired", retired, 32'd1);
        chk("post_reset_error", 32'(error), 32'd0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
